// File: rtl/multisum_initiator_if.sv
// Handshake bundle shared by the layer datapath, the multisum initiator and the four-operand summer.
`timescale 1ns/1ps
interface multisum_initiator_if #(parameter int W = 32);
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op0, op1, op2, op3;
  logic [W-1:0] ms_in0, ms_in1, ms_in2, ms_in3;
  logic         ms_start;
  logic [W-1:0] ms_sum;
  logic         ms_done;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;

  // master is the initiator's view; slave is the surrounding datapath/summer view
  modport master (
    input  op_valid, op0, op1, op2, op3, ms_sum, ms_done, res_ready,
    output op_ready, ms_in0, ms_in1, ms_in2, ms_in3, ms_start, res_valid, res_data
  );
  modport slave (
    output op_valid, op0, op1, op2, op3, ms_sum, ms_done, res_ready,
    input  op_ready, ms_in0, ms_in1, ms_in2, ms_in3, ms_start, res_valid, res_data
  );
endinterface

// File: rtl/multisum_initiator.sv
// Requester side of the four-operand summer start/done protocol with a timeout watchdog
// and a count of delivered results.
`timescale 1ns/1ps
module multisum_initiator #(
  parameter int W       = 32,
  parameter int TIMEOUT = 16,
  parameter int CW      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multisum_initiator_if.master bus,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CW-1:0]        txn_count
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESULT} state_t;

  state_t         state, state_n;
  logic [WDW-1:0] wd, wd_n;
  logic [W-1:0]   ops_q [4];
  logic [W-1:0]   ops_n [4];
  logic           start_q, start_n;
  logic           rv_q, rv_n;
  logic [W-1:0]   rd_q, rd_n;
  logic           terr_n;
  logic [CW-1:0]  cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wd          <= '0;
      ops_q       <= '{default: '0};
      start_q     <= 1'b0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
      timeout_err <= 1'b0;
      txn_count   <= '0;
    end else begin
      state       <= state_n;
      wd          <= wd_n;
      ops_q       <= ops_n;
      start_q     <= start_n;
      rv_q        <= rv_n;
      rd_q        <= rd_n;
      timeout_err <= terr_n;
      txn_count   <= cnt_n;
    end
  end

  // Done is checked before the watchdog so a completion on the last allowed cycle still counts.
  always_comb begin
    state_n = state;
    wd_n    = wd;
    ops_n   = ops_q;
    start_n = 1'b0;
    rv_n    = rv_q;
    rd_n    = rd_q;
    terr_n  = timeout_err;
    cnt_n   = txn_count;
    case (state)
      S_IDLE: begin
        if (bus.op_valid) begin
          ops_n   = '{bus.op0, bus.op1, bus.op2, bus.op3};
          start_n = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        wd_n    = '0;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.ms_done) begin
          rd_n    = bus.ms_sum;
          rv_n    = 1'b1;
          state_n = S_RESULT;
        end else if (wd == WDW'(TIMEOUT - 1)) begin
          terr_n  = 1'b1;
          state_n = S_IDLE;
        end else begin
          wd_n = wd + 1'b1;
        end
      end
      S_RESULT: begin
        if (bus.res_ready) begin
          rv_n    = 1'b0;
          cnt_n   = txn_count + 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign busy          = (state != S_IDLE);
  assign bus.op_ready  = (state == S_IDLE) && !reset;
  assign bus.ms_in0    = ops_q[0];
  assign bus.ms_in1    = ops_q[1];
  assign bus.ms_in2    = ops_q[2];
  assign bus.ms_in3    = ops_q[3];
  assign bus.ms_start  = start_q;
  assign bus.res_valid = rv_q;
  assign bus.res_data  = rd_q;

endmodule

// File: doc/multisum_initiator.md
Name: multisum_initiator

Overview:
Requester side of the four-operand summer's start/done protocol.
- Accepts operand quads from the layer datapath over a valid/ready handshake.
- Drives and holds the summer operands and pulses start.
- Waits for done, captures the sum and returns it downstream over a valid/ready handshake.
- Guards the transaction with a timeout watchdog and keeps a completed-transaction count.

Parameters:
W, 32, operand/sum width (must match the summer)
TIMEOUT, 16, maximum cycles spent in WAIT before aborting (>= 8)
CW, 16, width of txn_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  upstream operand quad valid
op_ready  out  1  initiator can accept a quad
op0, op1, op2, op3  in  W each  operands
ms_in0, ms_in1, ms_in2, ms_in3  out  W each  operands to the summer (registered)
ms_start  out  1  start request to the summer (registered, one-cycle pulse)
ms_sum  in  W  summer result
ms_done  in  1  summer completion strobe (one cycle)
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_data  out  W  captured sum
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky abort flag
txn_count  out  CW  number of results delivered, wraps

Behaviour:
Reset (synchronous, active-high, clk):
- All outputs go to 0.
- State goes to IDLE and the watchdog counter clears.
- Reset has priority over every other event, including mid-transaction.
- The summer shares the same reset, so both ends realign.

State machine:
- IDLE:
  - op_ready=1.
  - On op_valid&&op_ready: register op0..op3 into ms_in0..3, then go to START.
- START:
  - ms_start=1 for exactly this one cycle.
  - Watchdog cleared; next state is WAIT.
- WAIT:
  - ms_start=0; watchdog increments each cycle.
  - If ms_done=1: capture ms_sum into res_data, set res_valid=1, go to RESULT.
  - Else, if watchdog reaches TIMEOUT-1: set timeout_err=1 and go to IDLE; no result is produced.
  - If ms_done and the timeout coincide, done wins.
- RESULT:
  - res_valid=1 and res_data held stable.
  - On res_ready: res_valid=0, txn_count+1 (modulo 2^CW), go to IDLE.
- op_ready=0 in START, WAIT and RESULT; only one transaction is ever outstanding.

Operand and strobe rules:
- ms_in0..3 hold their value from the accept edge until the next accept. The summer samples them on successive cycles after start, so operands must never change mid-transaction.
- ms_done seen outside WAIT is ignored and has no state effect.
- ms_sum is sampled only in the ms_done cycle. The summer clears its sum register when it returns to idle, so there is no later sampling window.

Timing:
- With the summer attached, accept at cycle A gives:
  - ms_start high in A+1
  - ms_done high in A+7
  - res_valid high from A+8
- With res_ready tied high, the next quad is accepted at A+9 at the earliest.

Arithmetic and flags:
- Arithmetic is done in the summer. res_data is a W-bit copy of the summer result, so overflow wraps mod 2^W.
- timeout_err stays set until reset; later transactions proceed normally while it is set.

Test Plan:
1. Reset, res_ready=1, single quad 1,2,3,4 accepted at cycle A -> ms_start pulses only in A+1, res_valid rises at A+8 with res_data=10, txn_count=1.
2. Quad 0xFFFFFFFF,1,0,5 -> res_data=5 (wrap); operands ms_in0..3 stable A through A+8.
3. res_ready held low 10 cycles after res_valid -> res_data/res_valid held, op_ready=0 and op_valid ignored throughout; result transfers on first res_ready cycle, txn_count increments once.
4. Summer stub never asserts done -> timeout_err=1, state returns to IDLE after TIMEOUT cycles in WAIT, no res_valid. A following quad 5,5,5,5 with a real summer -> res_data=20, timeout_err remains 1.
5. Reset asserted in WAIT (cycle A+4) -> next cycle all outputs 0, busy=0. Then quad 7,0,0,1 -> res_data=8 with no stale result.
6. Spurious ms_done in IDLE, then 3 back-to-back quads with res_ready=1 -> no phantom result. Accepts at A, A+9, A+18; txn_count=3; txn_count wraps 0xFFFF->0 when preloaded by running 65536 transactions (or CW=2 variant: 4 transactions -> 0).
